openip_locked_stream_arbiter: RTL
=================================

// Module: openip_locked_stream_arbiter
// PURPOSE
//  N-input to 1-output packet stream arbiter built around openip_priority_arbiter.
//  Selects one requester per packet and locks the selection until the packet's last beat
//  completes. Prevents beats from different sources from interleaving.
//  Sits between multiple packet masters and a single downstream stream consumer.
// PARAMETERS
//  N           4   number of input streams (>=1); index 0 has highest fixed priority
//  DATA_WIDTH  32  payload width per beat
// PORTS
//  clk        in   1               clock, all state on rising edge
//  rst        in   1               asynchronous, active-high reset
//  in_valid   in   N               per-input beat valid
//  in_ready   out  N               per-input beat accept
//  in_data    in   N x DATA_WIDTH  packed [N-1:0][DATA_WIDTH-1:0] payload
//  in_last    in   N               per-input last beat of packet
//  out_valid  out  1               output beat valid
//  out_ready  in   1               downstream accept
//  out_data   out  DATA_WIDTH      selected payload
//  out_last   out  1               selected last flag
//  out_grant  out  N               one-hot current selection, 0 when out_valid=0
// BEHAVIOUR
//  State: IDLE / LOCKED, plus sel[N-1:0] one-hot register.
//  Reset: state=IDLE, sel=0, RR mask=all-ones. While rst=1, in_ready=0 and out_valid=0.
//  Zero latency: output is a combinational mux of the selected input. There is no storage.
//  IDLE: cand = priority_arbiter(req). Without RR, req=in_valid.
//   out_grant=cand, out_valid=|in_valid, in_ready=cand & {N{out_ready}}.
//   Handshake with last=1: stay IDLE, single-beat packet.
//   Else if out_valid=1: go LOCKED, sel<=cand. Any offered beat locks,
//   so out_valid/out_data never retract or switch source while stalled.
//  LOCKED: out_grant=sel, out_valid=|(in_valid&sel), in_ready=sel & {N{out_ready}}.
//   Non-selected inputs get in_ready=0, even if higher priority.
//   A bubble (selected in_valid=0) keeps the lock.
//   Handshake (out_valid&out_ready&out_last): go IDLE. The next packet arbitrates the
//   following cycle, so there is one cycle of arbitration after each multi-beat packet.
//  out_data/out_last = AND-OR mux with the grant. All zero when the grant is 0.
//  A reset mid-packet drops the lock immediately. Upstream must restart its packets.
//  N=1 degenerates to a pass-through with a lock flag.
// CONFIGURATION
//  OPENIP_LOCKED_STREAM_ARBITER_RR_EN defined: round-robin fairness.
//   mask register; masked = in_valid & mask.
//   req = masked if |masked, else in_valid (wrap-around).
//   On packet completion with grant g: mask <= ~(g | (g-1)), i.e. bits strictly above g.
//   If g = MSB, the mask becomes 0, which forces a wrap to in_valid.
//  Undefined: fixed priority, lowest index wins. No mask register exists.
// TESTING
//  1 N=4, in_valid=4'b1010, single-beat, out_ready=1 -> out_grant=4'b0010, in_ready=4'b0010,
//    next cycle grant=4'b1000.
//  2 Input2 sends 3-beat packet; input0 raises valid at beat 2 -> in_ready[0]=0
//    until input2 last handshake; input0 granted the cycle after.
//  3 IDLE, in_valid=4'b0100, out_ready=0 for 5 cycles, then in_valid[1] rises -> out_grant
//    stays 4'b0100, out_data stable, until handshake.
//  4 Bubble: selected valid low 2 cycles mid-packet while input0 valid -> lock held, out_valid=0,
//    in_ready[0]=0.
//  5 rst pulse asynchronously mid-packet -> in_ready=0 and out_valid=0 immediately;
//    after release, state=IDLE and fresh arbitration.
//  6 RR_EN, all 4 inputs always valid, single-beat -> grants 0,1,2,3,0 in successive
//    packets; without RR_EN -> grant 0 every cycle.

Source files
------------

// File: rtl/openip_locked_stream_arbiter.sv
// N-to-1 packet stream arbiter that locks the selected source until its last beat completes.
// Define OPENIP_LOCKED_STREAM_ARBITER_RR_EN for round-robin fairness; default is fixed priority.
module openip_locked_stream_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N-1:0]                     in_valid_i,
  output logic [N-1:0]                     in_ready_o,
  input  logic [N-1:0][DATA_WIDTH-1:0]     in_data_i,
  input  logic [N-1:0]                     in_last_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic                             out_last_o,
  output logic [N-1:0]                     out_grant_o
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [N-1:0]   req;
  logic [N-1:0]   cand;
  logic [N-1:0]   grant;
  logic           valid;
  logic           pkt_done;

`ifdef OPENIP_LOCKED_STREAM_ARBITER_RR_EN
  logic [N-1:0]   mask_q, mask_d;
  logic [N-1:0]   masked;

  // Fall back to the unmasked requests once everyone above the last winner is idle.
  always_comb begin
    masked = in_valid_i & mask_q;
    req    = (|masked) ? masked : in_valid_i;
  end

  always_comb begin
    mask_d = mask_q;
    if (pkt_done) begin
      mask_d = ~(out_grant_o | (out_grant_o - N'(1)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  always_comb begin
    req = in_valid_i;
  end
`endif

  // Fixed-priority pick: isolate the lowest set request bit.
  always_comb begin
    cand = req & (~req + N'(1));
  end

  always_comb begin
    grant = '0;
    valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant = cand;
        valid = |in_valid_i;
      end
      StLocked: begin
        grant = sel_q;
        valid = |(in_valid_i & sel_q);
      end
      default: begin
        grant = '0;
        valid = 1'b0;
      end
    endcase
    if (rst_i) begin
      grant = '0;
      valid = 1'b0;
    end
  end

  // Grant is suppressed during bubbles so the data/last mux reads back as zero.
  always_comb begin
    out_valid_o = valid;
    out_grant_o = valid ? grant : '0;
    in_ready_o  = out_grant_o & {N{out_ready_i}};
  end

  always_comb begin
    out_data_o = '0;
    out_last_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      out_data_o = out_data_o | (in_data_i[i] & {DATA_WIDTH{out_grant_o[i]}});
      out_last_o = out_last_o | (in_last_i[i] & out_grant_o[i]);
    end
  end

  always_comb begin
    pkt_done = out_valid_o & out_ready_i & out_last_o;
  end

  // Any offered beat that is not a completed single-beat packet takes the lock, so a stalled
  // output never switches source.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (out_valid_o && !pkt_done) begin
          state_d = StLocked;
          sel_d   = cand;
        end
      end
      StLocked: begin
        if (pkt_done) begin
          state_d = StIdle;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule
